// File: rtl/lfsr_gen.sv
// lfsr_gen: XNOR-feedback Fibonacci LFSR with a bounded rejection-sampling
// draw engine.
//
// The register steps either freely (enable) or while a draw is searching.
// A draw takes the low OUT_W bits of the register as a candidate each cycle.
// It accepts the first candidate below the captured limit. If it runs out
// of tries, it completes with rnd=0 and timeout set instead.
//
// State table (draw FSM):
//   state  | meaning
//   IDLE   | no draw in progress; req starts one (unless load is high)
//   SEARCH | evaluating one candidate per cycle; register steps every cycle
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   free-run step request
//   load       in   seed load strobe (wins over stepping, aborts a draw)
//   seed       in   [WIDTH]  seed value; all-ones is replaced by all-zeros
//   req        in   draw request, honoured only in IDLE
//   limit      in   [OUT_W]  exclusive upper bound for the draw, 0 = full range
//   state      out  [WIDTH]  current LFSR register
//   rnd        out  [OUT_W]  last drawn value, held until the next completion
//   rnd_valid  out  one-cycle pulse when a draw completes
//   timeout    out  qualifies rnd_valid: draw exhausted MAX_TRIES
//   busy       out  high while in SEARCH
//   wrapped    out  one-cycle pulse when the register returns to its reference
module lfsr_gen #(
  parameter int unsigned            WIDTH     = 6,
  parameter logic [WIDTH-1:0]       TAPS      = 6'b110000,
  parameter int unsigned            OUT_W     = 4,
  parameter int unsigned            MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic [WIDTH-1:0] state,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  output logic             timeout,
  output logic             busy,
  output logic             wrapped
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES - 1);

  typedef enum logic {IDLE, SEARCH} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, ref_q;
  logic [WIDTH-1:0] state_step;
  logic [WIDTH-1:0] load_val;
  logic             fb;
  logic             step_en;
  logic [CNT_W-1:0] tries_q;
  logic [OUT_W-1:0] lim_q;
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             last_try;
  logic             start;
  logic             draw_ok;
  logic             draw_to;
  logic             reject;
  logic [OUT_W-1:0] rnd_q;
  logic             rnd_valid_q, timeout_q, wrapped_q;

  // XNOR feedback keeps the all-zeros state legal; all-ones is the lockup state.
  assign fb         = ~^(state_q & TAPS);
  assign state_step = {state_q[WIDTH-2:0], fb};
  assign load_val   = (&seed) ? '0 : seed;
  assign step_en    = (enable || (fsm_q == SEARCH)) && !load;

  assign cand     = state_q[OUT_W-1:0];
  assign accept   = (lim_q == '0) || (cand < lim_q);
  assign last_try = (tries_q == TRY_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic. A load wins over evaluating the current candidate.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:   if (req && !load) fsm_d = SEARCH;
      SEARCH: begin
        if (load)                     fsm_d = IDLE;
        else if (accept || last_try)  fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Output / decision logic.
  always_comb begin
    busy    = 1'b0;
    start   = 1'b0;
    draw_ok = 1'b0;
    draw_to = 1'b0;
    reject  = 1'b0;
    case (fsm_q)
      IDLE:   start = req && !load;
      SEARCH: begin
        busy    = 1'b1;
        draw_ok = !load && accept;
        reject  = !load && !accept;
        draw_to = !load && !accept && last_try;
      end
      default: ;
    endcase
  end

  // Datapath: LFSR, reference, try counter, captured limit and draw results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= '0;
      ref_q       <= '0;
      tries_q     <= '0;
      lim_q       <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      if (load) begin
        state_q <= load_val;
        ref_q   <= load_val;
      end else if (step_en) begin
        state_q <= state_step;
      end

      // step_en already excludes load, so a load never produces a wrap.
      wrapped_q <= step_en && (state_step == ref_q);

      if (start) begin
        tries_q <= '0;
        lim_q   <= limit;
      end else if (reject) begin
        tries_q <= tries_q + 1'b1;
      end

      rnd_valid_q <= draw_ok || draw_to;
      timeout_q   <= draw_to;
      if (draw_ok)      rnd_q <= cand;
      else if (draw_to) rnd_q <= '0;
    end
  end

  assign state     = state_q;
  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign timeout   = timeout_q;
  assign wrapped   = wrapped_q;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 6: LFSR state width, legal range 3..32.
REQ-002 Parameter TAPS, default 6'b110000: WIDTH-bit feedback tap mask; bit i set means state bit i feeds the XNOR.
REQ-003 Parameter OUT_W, default 4: width of the drawn random value, 1..WIDTH.
REQ-004 Parameter MAX_TRIES, default 64: rejected candidates allowed per draw before timeout, 1..2^16-1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  free-run step request.
REQ-008 load  input  1  seed load strobe.
REQ-009 seed  input  WIDTH  seed value, sampled when load=1.
REQ-010 req  input  1  draw request, sampled only in IDLE.
REQ-011 limit  input  OUT_W  exclusive upper bound for a draw; 0 means full range.
REQ-012 state  output  WIDTH  current LFSR register.
REQ-013 rnd  output  OUT_W  last drawn value, held until the next draw completes.
REQ-014 rnd_valid  output  1  one-cycle pulse on draw completion.
REQ-015 timeout  output  1  qualifies rnd_valid; 1 means the draw exhausted MAX_TRIES.
REQ-016 busy  output  1  1 while in SEARCH.
REQ-017 wrapped  output  1  one-cycle pulse when state returns to its reference value.

Function
REQ-018 Step: fb = XNOR-reduction of (state & TAPS); state <= {state[WIDTH-2:0], fb}.
REQ-019 All-ones is the lockup state; it SHALL never be entered.
REQ-020 Step occurs when (enable=1 or FSM in SEARCH) and load=0.
REQ-021 load=1: state <= seed, or all-zeros if seed is all-ones; reference <= the same value; no step that cycle.
REQ-022 Priority: reset > load > step.
REQ-023 FSM has two states, IDLE and SEARCH; busy=1 only in SEARCH.
REQ-024 IDLE with req=1 and load=0: next state SEARCH; try counter cleared; limit captured into an internal register.
REQ-025 SEARCH, per cycle: candidate = state[OUT_W-1:0]; accepted if captured limit=0 or candidate < captured limit.
REQ-026 On accept: rnd <= candidate, rnd_valid=1, timeout=0 next cycle, return to IDLE; the state still steps that cycle.
REQ-027 On reject: try counter +1 and the state steps; if the counter reaches MAX_TRIES: rnd <= 0, rnd_valid=1, timeout=1, return to IDLE.
REQ-028 req in SEARCH is ignored; a req held high in the cycle rnd_valid is asserted starts a new draw from IDLE next cycle.
REQ-029 load in SEARCH aborts the draw: IDLE next cycle, no rnd_valid, rnd unchanged.
REQ-030 wrapped=1 in the cycle after a step whose next value equals the reference; load and reset never cause wrapped.
REQ-031 With maximal-length TAPS, wrapped pulses every 2^WIDTH-1 steps.
REQ-032 enable has no effect on a draw in progress; SEARCH always steps.

Reset
REQ-033 reset=1: state=0, reference=0, FSM=IDLE, try counter=0, rnd=0, rnd_valid=0, timeout=0, busy=0, wrapped=0.
REQ-034 reset takes effect regardless of load, req or FSM state, including mid-draw.

Verification
REQ-035 Default params; reset, then enable=1 for 7 cycles -> state 000000, 000001, 000011, 000111, 001111, 011111, 111110, 111101.
REQ-036 enable=1 for 63 cycles after reset -> exactly one wrapped pulse, coinciding with state returning to 000000; never 111111.
REQ-037 load, seed=111111 -> state=000000; load, seed=000011 with enable=1 the same cycle -> state=000011, no step.
REQ-038 After reset, req=1 with limit=4 -> busy one cycle, then rnd=0, rnd_valid=1, timeout=0, state=000001.
REQ-039 MAX_TRIES=4; load seed=000111; req, limit=4 -> candidates 7, 15, 15, 14 rejected, then rnd=0, timeout=1, rnd_valid=1.
REQ-040 Reset or load asserted during SEARCH -> IDLE next cycle, no rnd_valid; reset also zeroes state.
